x7seg_scan: RTL and testbench

X7SEG_SCAN -- requirements
Module: x7seg_scan

---
 rtl/x7seg_pkg.sv | 17 +
 rtl/x7seg_prescaler.sv | 36 +++
 rtl/x7seg_scan.sv | 101 ++++++++++
 tb/tb_x7seg_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/x7seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// segment vector type, blank pattern and the active-low hex glyph table.
package x7seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns indexed by nibble value 0..F.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/x7seg_prescaler.sv
// Free-running divider that marks the last clock of every CLK_DIV-cycle
// digit slot with a combinational tick.
module x7seg_prescaler
    import x7seg_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/x7seg_scan.sv
// Time-multiplexed seven-segment driver with load-strobed shadow registers.
// Define X7SEG_LZB_EN to enable leading-zero blanking of the upper digits.
module x7seg_scan
    import x7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                a_to_g
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    logic                    tick;
    logic [IW-1:0]           idx_q,  idx_d;
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]   dp_q,   dp_d;
    logic [NUM_DIGITS-1:0]   en_q,   en_d;
    logic [NUM_DIGITS-1:0]   an_q,   an_d;
    seg_t                    seg_q,  seg_d;
    logic [NUM_DIGITS-1:0]   blank;

    x7seg_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
        data_d = load ? data_in  : data_q;
        dp_d   = load ? dp_in    : dp_q;
        en_d   = load ? digit_en : en_q;
    end

`ifdef X7SEG_LZB_EN
    logic lead_zero;

    // Walk down from the top digit; disabled digits do not break a zero run.
    always_comb begin
        blank     = ~en_q;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (en_q[i]) begin
                lead_zero = lead_zero & (data_q[4*i +: 4] == 4'h0) & ~dp_q[i];
            end
            if (lead_zero) begin
                blank[i] = 1'b1;
            end
        end
    end
`else
    assign blank = ~en_q;
`endif

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((idx_q == IW'(i)) && !blank[i]) begin
                an_d[i] = 1'b0;
                seg_d   = {~dp_q[i], GLYPH_TABLE[data_q[4*i +: 4]]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            data_q <= '0;
            dp_q   <= '0;
            en_q   <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
            dp_q   <= dp_d;
            en_q   <= en_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an     = an_q;
    assign a_to_g = seg_q;

endmodule

// File: tb/tb_x7seg_scan.sv
// Self-checking bench for x7seg_scan (4 digits, 4 clocks per slot); follows
// X7SEG_LZB_EN when it is defined for the build.
module tb_x7seg_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        load   = 1'b0;
    logic [15:0] dataIn = '0;
    logic [3:0]  dpIn   = '0;
    logic [3:0]  enIn   = '0;
    logic [3:0]  an;
    logic [7:0]  aToG;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    x7seg_scan #(
        .NUM_DIGITS (N),
        .CLK_DIV    (DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data_in  (dataIn),
        .dp_in    (dpIn),
        .digit_en (enIn),
        .an       (an),
        .a_to_g   (aToG)
    );

    // Display image of one slot, returned as {an, segments}.
    function automatic logic [11:0] expectedSlot(logic [15:0] d, logic [3:0] dp,
                                                 logic [3:0] en, int slot);
        logic [3:0] nib;
        logic       isBlank;
        int         lead;
        nib     = d[4*slot +: 4];
        isBlank = !en[slot];
`ifdef X7SEG_LZB_EN
        lead = -1;
        for (int j = 0; j < N; j++) begin
            if (en[j] && (d[4*j +: 4] != 4'h0 || dp[j])) lead = j;
        end
        if (slot > 0 && slot > lead) isBlank = 1'b1;
`else
        lead = 0;
`endif
        if (isBlank) return {4'hF, 8'hFF};
        return {~(4'b0001 << slot), ~dp[slot], GLYPHS[nib]};
    endfunction

    logic [15:0] mData;
    logic [3:0]  mDp;
    logic [3:0]  mEn;
    int          kCount;
    logic [3:0]  expAn;
    logic [7:0]  expSeg;
    logic        modelValid = 1'b0;

    // Slot shown after edge k is (k-1)/DIV mod N, k counted from reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mData      <= '0;
            mDp        <= '0;
            mEn        <= '0;
            kCount     <= 0;
            expAn      <= 4'hF;
            expSeg     <= 8'hFF;
            modelValid <= 1'b1;
        end else begin
            {expAn, expSeg} <= expectedSlot(mData, mDp, mEn, (kCount / DIV) % N);
            if (load) begin
                mData <= dataIn;
                mDp   <= dpIn;
                mEn   <= enIn;
            end
            kCount <= kCount + 1;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            total++;
            if (an !== expAn || aToG !== expSeg) begin
                bad++;
                $display("[TB] FAIL cycleCheck t=%0t got an=%b seg=%h want an=%b seg=%h",
                         $time, an, aToG, expAn, expSeg);
            end
        end
    end

    task automatic checkOutput(string name, logic [3:0] wantAn, logic [7:0] wantSeg);
        total++;
        if (an !== wantAn || aToG !== wantSeg) begin
            bad++;
            $display("[TB] FAIL %s t=%0t got an=%b seg=%h want an=%b seg=%h",
                     name, $time, an, aToG, wantAn, wantSeg);
        end
    endtask

    // Reset pulse, then a single load captured on the first edge after release.
    task automatic applyStimulus(logic [15:0] d, logic [3:0] dp, logic [3:0] en);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        load   = 1'b1;
        dataIn = d;
        dpIn   = dp;
        enIn   = en;
        @(posedge clk);
        #2 load = 1'b0;
    endtask

    task automatic checkSlots(string name, logic [15:0] ans, logic [31:0] segs);
        for (int s = 0; s < N; s++) begin
            repeat ((s == 0) ? 2 : 4) @(posedge clk);
            @(negedge clk);
            checkOutput(name, ans[4*s +: 4], segs[8*s +: 8]);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (32) @(posedge clk);
        @(negedge clk);
        checkOutput("idleBlank", 4'hF, 8'hFF);

        applyStimulus(16'h12AF, 4'h0, 4'hF);
        checkSlots("hexScan", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {8'hF9, 8'hA4, 8'h88, 8'h8E});

        applyStimulus(16'h0005, 4'b0010, 4'hF);
`ifdef X7SEG_LZB_EN
        checkSlots("zeroDp", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                   {8'hFF, 8'hFF, 8'h40, 8'h92});
`else
        checkSlots("zeroDp", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                   {8'hC0, 8'hC0, 8'h40, 8'h92});
`endif

        applyStimulus(16'h12AF, 4'h0, 4'b1011);
        checkSlots("digitEnable", {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                   {8'hF9, 8'hFF, 8'h88, 8'h8E});

        applyStimulus(16'h0000, 4'h0, 4'hF);
        repeat (2) @(posedge clk);
        #2 load = 1'b1;
        dataIn = 16'h9999;
        @(posedge clk);
        #2 load = 1'b0;
        @(negedge clk);
        checkOutput("loadAtTickOld", 4'b1110, 8'hC0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("loadAtTickNew", 4'b1101, 8'h90);

        applyStimulus(16'h12AF, 4'h0, 4'hF);
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("beforeReset", 4'b1011, 8'hA4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("resetMidScan", 4'hF, 8'hFF);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("shadowCleared", 4'hF, 8'hFF);
        load   = 1'b1;
        dataIn = 16'h12AF;
        dpIn   = 4'h0;
        enIn   = 4'hF;
        @(posedge clk);
        #2 load = 1'b0;
        @(negedge clk);
        checkOutput("restartSlot0", 4'hF, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        checkOutput("restartSlot1", 4'b1101, 8'h88);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("restartSlot2", 4'b1011, 8'hA4);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
